// File: rtl/xdma_narrow_pkg.sv
// Shared definitions for the xdma narrow-channel arbiter.
package xdma_narrow_pkg;

  typedef enum logic {IDLE, LOCKED} narrow_arb_state_e;

  localparam int FINISH = 0;
  localparam int GRANT  = 1;
  localparam int CFG    = 2;

endpackage

// File: rtl/find_first_one_idx.sv
// Index of the highest set bit of a vector, plus an any-bit-set flag.
module find_first_one_idx #(
  parameter int N     = 3,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     vec,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  // Ascending scan: the last set bit seen (the highest index) wins.
  always_comb begin
    idx = '0;
    for (int i = 0; i < N; i++) begin
      if (vec[i]) idx = IDX_W'(i);
    end
  end

  assign any = |vec;

endmodule

// File: rtl/xdma_narrow_arbiter.sv
// Fixed-priority (highest index) arbiter with transfer locking and a one-entry output slot.
module xdma_narrow_arbiter
  import xdma_narrow_pkg::*;
#(
  parameter int N      = 3,
  parameter int DATA_W = 64,
  parameter int IDX_W  = $clog2(N)
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [N-1:0]               req_valid_i,
  input  logic [N-1:0]               req_last_i,
  input  logic [N-1:0][DATA_W-1:0]   req_data_i,
  output logic [N-1:0]               req_ready_o,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [DATA_W-1:0]          out_data_o,
  output logic                       out_last_o,
  output logic [IDX_W-1:0]           out_idx_o,
  output logic                       busy_o
);

  if (N < 2) begin : g_bad_n
    $error("xdma_narrow_arbiter: N must be >= 2");
  end

  narrow_arb_state_e state_q, state_d;
  logic [IDX_W-1:0]  lock_idx_q, lock_idx_d;
  logic [IDX_W-1:0]  winner, sel_idx;
  logic              any_valid, sel_valid, slot_free, accept, sel_last;
  logic [N-1:0]      sel_onehot;

  find_first_one_idx #(.N(N), .IDX_W(IDX_W)) u_ffo (
    .vec (req_valid_i),
    .idx (winner),
    .any (any_valid)
  );

  assign slot_free  = !out_valid_o || out_ready_i;
  assign sel_idx    = (state_q == LOCKED) ? lock_idx_q : winner;
  assign sel_valid  = (state_q == LOCKED) ? req_valid_i[lock_idx_q] : any_valid;
  assign sel_onehot = {{(N-1){1'b0}}, 1'b1} << sel_idx;
  assign sel_last   = req_last_i[sel_idx];

  // A locked source that drops valid stalls the channel without releasing its grant.
  assign req_ready_o = sel_onehot & {N{slot_free && sel_valid && !rst_i}};
  assign accept      = |req_ready_o;

  always_comb begin
    state_d    = state_q;
    lock_idx_d = lock_idx_q;
    case (state_q)
      IDLE: begin
        if (accept && !sel_last) begin
          state_d    = LOCKED;
          lock_idx_d = winner;
        end
      end
      LOCKED: begin
        if (accept && sel_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      lock_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      lock_idx_q <= lock_idx_d;
    end
  end

  // Output slot: reload on accept, otherwise drain on downstream ready, otherwise hold.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_valid_o <= 1'b0;
      out_data_o  <= '0;
      out_last_o  <= 1'b0;
      out_idx_o   <= '0;
    end else if (accept) begin
      out_valid_o <= 1'b1;
      out_data_o  <= req_data_i[sel_idx];
      out_last_o  <= sel_last;
      out_idx_o   <= sel_idx;
    end else if (out_ready_i) begin
      out_valid_o <= 1'b0;
    end
  end

  assign busy_o = (state_q == LOCKED) || out_valid_o;

endmodule
